// File: rtl/lcd12864_cmd_arbiter_if.sv
// Request-side handshake bundle for lcd12864_cmd_arbiter: two single-byte write requesters.
// The requester side uses the master modport; the arbiter uses slave.
interface lcd12864_cmd_arbiter_if;
    logic       req0_valid;
    logic       req0_rs;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_rs;
    logic [7:0] req1_data;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_rs, req0_data,
        output req1_valid, req1_rs, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_rs, req0_data,
        input  req1_valid, req1_rs, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/lcd12864_cmd_arbiter.sv
// Shares an ST7920 LCD12864 parallel write bus between two requesters after running the
// power-up/init sequence, generating lcd_en with setup, pulse and execution-wait timing.
module lcd12864_cmd_arbiter #(
    parameter int T_PWRUP = 2000000,
    parameter int T_AS    = 4,
    parameter int T_EH    = 12,
    parameter int T_EXEC  = 3600,
    parameter int T_CLR   = 80000,
    parameter int CW      = 21
) (
    input  logic                        clk,
    input  logic                        rst_n,
    lcd12864_cmd_arbiter_if.slave       req,
    output logic                        init_done,
    output logic                        busy,
    output logic                        lcd_rs,
    output logic                        lcd_rw,
    output logic                        lcd_en,
    output logic [7:0]                  lcd_dat
);

    typedef enum logic [2:0] {
        PWRUP,
        SETUP,
        EHIGH,
        WAIT,
        IDLE
    } state_t;

    localparam logic [CW-1:0] PWRUP_LIM = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] AS_LIM    = CW'(T_AS - 1);
    localparam logic [CW-1:0] EH_LIM    = CW'(T_EH - 1);
    localparam logic [CW-1:0] EXEC_LIM  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] CLR_LIM   = CW'(T_CLR - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    idx, idx_nx;
    logic          last_grant, last_grant_nx;
    logic          rs_nx;
    logic [7:0]    dat_nx;
    logic          ready0_q, ready1_q, ready0_nx, ready1_nx;
    logic          init_done_nx;
    logic          grant1;
    logic [CW-1:0] wait_lim;

    function automatic logic [7:0] rom(input logic [2:0] i);
        case (i)
            3'd0:    rom = 8'h30;
            3'd1:    rom = 8'h30;
            3'd2:    rom = 8'h0C;
            3'd3:    rom = 8'h01;
            3'd4:    rom = 8'h06;
            default: rom = 8'h00;
        endcase
    endfunction

    assign lcd_rw         = 1'b0;
    assign req.req0_ready = ready0_q;
    assign req.req1_ready = ready1_q;

    // Clear-display needs the long post-strobe wait; the held output byte identifies it.
    assign wait_lim = (!lcd_rs && lcd_dat == 8'h01) ? CLR_LIM : EXEC_LIM;
    assign grant1   = req.req1_valid && (!req.req0_valid || !last_grant);

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt + 1'b1;
        idx_nx        = idx;
        last_grant_nx = last_grant;
        rs_nx         = lcd_rs;
        dat_nx        = lcd_dat;
        ready0_nx     = 1'b0;
        ready1_nx     = 1'b0;
        init_done_nx  = init_done;
        case (state)
            PWRUP: begin
                if (cnt == PWRUP_LIM) begin
                    state_nx = SETUP;
                    cnt_nx   = '0;
                    rs_nx    = 1'b0;
                    dat_nx   = rom(idx);
                end
            end
            SETUP: begin
                if (cnt == AS_LIM) begin
                    state_nx = EHIGH;
                    cnt_nx   = '0;
                end
            end
            EHIGH: begin
                if (cnt == EH_LIM) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end
            end
            WAIT: begin
                if (cnt == wait_lim) begin
                    cnt_nx = '0;
                    if (idx < 3'd4) begin
                        idx_nx   = idx + 3'd1;
                        rs_nx    = 1'b0;
                        dat_nx   = rom(idx + 3'd1);
                        state_nx = SETUP;
                    end else if (idx == 3'd4) begin
                        idx_nx       = 3'd5;
                        init_done_nx = 1'b1;
                        state_nx     = IDLE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            IDLE: begin
                cnt_nx = '0;
                if (req.req0_valid || req.req1_valid) begin
                    state_nx      = SETUP;
                    last_grant_nx = grant1;
                    ready0_nx     = !grant1;
                    ready1_nx     = grant1;
                    rs_nx         = grant1 ? req.req1_rs   : req.req0_rs;
                    dat_nx        = grant1 ? req.req1_data : req.req0_data;
                end
            end
            default: begin
                state_nx = PWRUP;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs follow the next state so lcd_en and busy are registered yet aligned with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PWRUP;
            cnt        <= '0;
            idx        <= 3'd0;
            last_grant <= 1'b1;
            lcd_rs     <= 1'b0;
            lcd_dat    <= 8'h00;
            lcd_en     <= 1'b0;
            busy       <= 1'b1;
            ready0_q   <= 1'b0;
            ready1_q   <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            last_grant <= last_grant_nx;
            lcd_rs     <= rs_nx;
            lcd_dat    <= dat_nx;
            lcd_en     <= (state_nx == EHIGH);
            busy       <= (state_nx != IDLE);
            ready0_q   <= ready0_nx;
            ready1_q   <= ready1_nx;
            init_done  <= init_done_nx;
        end
    end

endmodule

// File: tb/tb_lcd12864_cmd_arbiter.sv
// Directed bench for lcd12864_cmd_arbiter with shortened timing (PWRUP 10, AS 2, EH 3, EXEC 5, CLR 20).
// Times are counted in falling edges after the relevant event.
module tb_lcd12864_cmd_arbiter;

    localparam int T_PWRUP = 10;
    localparam int T_AS    = 2;
    localparam int T_EH    = 3;
    localparam int T_EXEC  = 5;
    localparam int T_CLR   = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       init_done, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_dat;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    lcd12864_cmd_arbiter_if bus ();

    lcd12864_cmd_arbiter #(
        .T_PWRUP (T_PWRUP),
        .T_AS    (T_AS),
        .T_EH    (T_EH),
        .T_EXEC  (T_EXEC),
        .T_CLR   (T_CLR),
        .CW      (21)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus),
        .init_done (init_done),
        .busy      (busy),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_dat   (lcd_dat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_requests();
        bus.req0_valid = 1'b0; bus.req0_rs = 1'b0; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_rs = 1'b0; bus.req1_data = 8'h00;
    endtask

    // Ends on the falling edge where reset is released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_requests();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_en(input logic lvl, input int maxc, output int n);
        n = 0;
        while (lcd_en !== lvl && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_ready(input int maxc, output int n);
        n = 0;
        while (bus.req0_ready !== 1'b1 && bus.req1_ready !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_init(input int maxc, output int n);
        n = 0;
        while (init_done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input int maxc, output int n);
        n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_requests();
        #1;
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b expected 0", lcd_en); end
        checks++; if ({lcd_rs, lcd_dat} !== 9'h000) begin errors++; $display("[TB] FAIL reset_rs_dat: got %h expected 000", {lcd_rs, lcd_dat}); end
        checks++; if (lcd_rw !== 1'b0) begin errors++; $display("[TB] FAIL reset_rw: got %b expected 0", lcd_rw); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready}); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_done: got %b expected 0", init_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
    endtask

    task automatic test_init();
        int n;
        logic [7:0] exp_b [5] = '{8'h30, 8'h30, 8'h0C, 8'h01, 8'h06};
        do_reset();
        wait_en(1'b1, 40, n);
        checks++; if (n != 12) begin errors++; $display("[TB] FAIL init_first_en: got %0d expected 12", n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if ({lcd_rs, lcd_dat} !== {1'b0, exp_b[i]}) begin errors++; $display("[TB] FAIL init_byte%0d: got %h expected %h", i, {lcd_rs, lcd_dat}, {1'b0, exp_b[i]}); end
            wait_en(1'b0, 20, n);
            checks++; if (n != 3) begin errors++; $display("[TB] FAIL init_high%0d: got %0d expected 3", i, n); end
            if (i < 4) begin
                wait_en(1'b1, 40, n);
                checks++; if (n != ((i == 3) ? 22 : 7)) begin errors++; $display("[TB] FAIL init_gap%0d: got %0d expected %0d", i, n, (i == 3) ? 22 : 7); end
            end
        end
        checks++; if ({init_done, busy} !== 2'b01) begin errors++; $display("[TB] FAIL init_last_wait: got %b expected 01", {init_done, busy}); end
        wait_init(20, n);
        checks++; if (n != 5) begin errors++; $display("[TB] FAIL init_done_time: got %0d expected 5", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL init_busy: got %b expected 0", busy); end
    endtask

    task automatic test_pending();
        int n;
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h41;
        wait_ready(150, n);
        checks++; if (n != 76) begin errors++; $display("[TB] FAIL pend_ready_time: got %0d expected 76", n); end
        checks++; if ({init_done, bus.req0_ready, bus.req1_ready} !== 3'b110) begin errors++; $display("[TB] FAIL pend_ready: got %b expected 110", {init_done, bus.req0_ready, bus.req1_ready}); end
        checks++; if ({lcd_rs, lcd_dat} !== 9'h141) begin errors++; $display("[TB] FAIL pend_byte: got %h expected 141", {lcd_rs, lcd_dat}); end
        @(negedge clk);
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_ready_pulse: got %b expected 0", bus.req0_ready); end
        bus.req0_valid = 1'b0;
        wait_en(1'b1, 10, n);
        checks++; if (n != 1) begin errors++; $display("[TB] FAIL pend_en_rise: got %0d expected 1", n); end
        wait_idle(30, n);
    endtask

    task automatic test_round_robin();
        int n;
        int last;
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] exp_d [4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
        do_reset();
        wait_init(100, n);
        checks++; if (n != 75) begin errors++; $display("[TB] FAIL rr_init_time: got %0d expected 75", n); end
        bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'hA0;
        bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'hB0;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready(30, n);
            checks++; if ({bus.req1_ready, bus.req0_ready} !== exp_g[k]) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, {bus.req1_ready, bus.req0_ready}, exp_g[k]); end
            checks++; if (lcd_dat !== exp_d[k]) begin errors++; $display("[TB] FAIL rr_data%0d: got %h expected %h", k, lcd_dat, exp_d[k]); end
            if (k > 0) begin
                checks++; if (cyc - last != 11) begin errors++; $display("[TB] FAIL rr_interval%0d: got %0d expected 11", k, cyc - last); end
            end
            last = cyc;
            @(negedge clk);
            if (k[0]) bus.req1_data = bus.req1_data + 8'h01;
            else      bus.req0_data = bus.req0_data + 8'h01;
            if (k == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end
        wait_idle(30, n);
    endtask

    task automatic test_clear();
        int n;
        for (int c = 0; c < 2; c++) begin
            bus.req1_valid = 1'b1; bus.req1_rs = c[0]; bus.req1_data = 8'h01;
            wait_ready(20, n);
            checks++; if ({bus.req1_ready, lcd_rs, lcd_dat} !== {1'b1, c[0], 8'h01}) begin errors++; $display("[TB] FAIL clr_accept%0d: got %h expected %h", c, {bus.req1_ready, lcd_rs, lcd_dat}, {1'b1, c[0], 8'h01}); end
            wait_en(1'b1, 10, n);
            checks++; if (n != 2) begin errors++; $display("[TB] FAIL clr_setup%0d: got %0d expected 2", c, n); end
            bus.req1_valid = 1'b0;
            wait_en(1'b0, 10, n);
            wait_idle(40, n);
            checks++; if (n != ((c == 0) ? 20 : 5)) begin errors++; $display("[TB] FAIL clr_wait%0d: got %0d expected %0d", c, n, (c == 0) ? 20 : 5); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int nready = 0;
        int last = 0;
        int high_run = 0;
        logic prev_busy = busy;
        logic prev_en = lcd_en;
        logic upd = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'hC0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (upd) begin
                upd = 1'b0;
                if (nready == 4) bus.req0_valid = 1'b0;
                else bus.req0_data = 8'(8'hC0 + nready);
            end
            if (bus.req0_ready === 1'b1) begin
                checks++; if (prev_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_busy%0d: got %b expected 0", nready, prev_busy); end
                checks++; if (lcd_dat !== 8'(8'hC0 + nready)) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", nready, lcd_dat, 8'(8'hC0 + nready)); end
                if (nready > 0) begin
                    checks++; if (cyc - last != 11) begin errors++; $display("[TB] FAIL b2b_interval%0d: got %0d expected 11", nready, cyc - last); end
                end
                last = cyc;
                nready++;
                upd = 1'b1;
            end
            if (lcd_en === 1'b1 && prev_en === 1'b0) begin
                checks++; if (cyc - last != 2) begin errors++; $display("[TB] FAIL b2b_setup: got %0d expected 2", cyc - last); end
            end
            if (lcd_en === 1'b1) high_run++;
            else if (prev_en === 1'b1) begin
                checks++; if (high_run != 3) begin errors++; $display("[TB] FAIL b2b_high: got %0d expected 3", high_run); end
                high_run = 0;
            end
            prev_en = lcd_en;
            prev_busy = busy;
        end
        checks++; if (nready != 4) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 4", nready); end
        wait_idle(30, n);
    endtask

    task automatic test_reset_mid();
        int n;
        logic saw = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h55;
        wait_ready(20, n);
        wait_en(1'b1, 10, n);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        checks++; if (lcd_en !== 1'b1) begin errors++; $display("[TB] FAIL mid_en_before: got %b expected 1", lcd_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({lcd_en, init_done, busy} !== 3'b001) begin errors++; $display("[TB] FAIL mid_async: got %b expected 001", {lcd_en, init_done, busy}); end
        checks++; if ({lcd_rs, lcd_dat} !== 9'h000) begin errors++; $display("[TB] FAIL mid_rs_dat: got %h expected 000", {lcd_rs, lcd_dat}); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_en(1'b1, 40, n);
        checks++; if (n != 12) begin errors++; $display("[TB] FAIL mid_first_en: got %0d expected 12", n); end
        checks++; if ({lcd_rs, lcd_dat} !== 9'h030) begin errors++; $display("[TB] FAIL mid_first_byte: got %h expected 030", {lcd_rs, lcd_dat}); end
        wait_init(100, n);
        checks++; if (n != 63) begin errors++; $display("[TB] FAIL mid_init_time: got %0d expected 63", n); end
        checks++; if (lcd_dat !== 8'h06) begin errors++; $display("[TB] FAIL mid_last_byte: got %h expected 06", lcd_dat); end
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1 || busy !== 1'b0) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_replay: got %b expected 0", saw); end
    endtask

    initial begin
        clear_requests();
        test_reset();
        test_init();
        test_pending();
        test_round_robin();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
